// File: rtl/pending_index_encoder_pkg.sv
// Shared constants and FSM encoding for the pending index encoder.
// The width constants are also used by the regfile write-select decoder.
package pending_index_encoder_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/pending_index_encoder_lsb_enc.sv
// Purely combinational lowest-set-bit priority encoder.
// A zero input gives index 0 with any_set low.
module lsb_priority_encoder_32
    import pending_index_encoder_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx     = '0;
        any_set = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_index_encoder.sv
// Collects multi-hot register-select masks into a sticky pending set and
// drains it as a stream of indices, lowest index first on every scan.
//
// Handshake: out_valid/out_idx are held stable until the cycle in which
// out_valid & out_ready are both high; that cycle transfers exactly one
// index. out_valid never depends combinationally on out_ready.
module pending_index_encoder
    import pending_index_encoder_pkg::*;
(
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_mask,
    input  logic             flush,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic             empty,
    output state_t           fsm_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             load;
    logic             handshake;
    logic [WIDTH-1:0] load_bit;
    logic [WIDTH-1:0] set_bits;

    // Selection looks only at the registered pending set, so a new request
    // can never reach out_idx in the cycle it arrives.
    lsb_priority_encoder_32 u_enc (
        .vec     (pending_q),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    assign handshake = (state_q == PRESENT) && out_ready;

    // Next-state logic: decide whether to load a new index this edge.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (enc_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear/set merge: a bit re-requested while being loaded stays pending.
    always_comb begin
        load_bit  = load ? (WIDTH'(1) << enc_idx) : '0;
        set_bits  = req_valid ? req_mask : '0;
        pending_d = (pending_q & ~load_bit) | set_bits;
        out_idx_d = load ? enc_idx : out_idx_q;
    end

    // State registers; reset and flush both clear everything and drop requests.
    always_ff @(posedge clock) begin
        if (ctrl_reset || flush) begin
            state_q   <= IDLE;
            pending_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign empty     = (pending_q == '0) && !out_valid;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_pending_index_encoder.sv
// Bench for pending_index_encoder: directed corner sequences, a table of
// masks drained with ready held high, and random masks drained under random
// backpressure. Expected indices are queued when a request is driven and
// popped by a monitor on every handshake.
module tb_pending_index_encoder;
    import pending_index_encoder_pkg::*;

    logic             clock = 1'b0;
    logic             ctrl_reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [WIDTH-1:0] req_mask = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] pending;
    logic             empty;
    state_t           fsm_state;

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    logic [IDX_W-1:0] first_idx = '0;
    logic [IDX_W-1:0] last_idx = '0;
    logic [IDX_W-1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] mask;
        int               exp_n;
        logic [IDX_W-1:0] exp_first;
        logic [IDX_W-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    pending_index_encoder dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req_valid  (req_valid),
        .req_mask   (req_mask),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .pending    (pending),
        .empty      (empty),
        .fsm_state  (fsm_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Monitor: every accepted index must match the head of the expected queue.
    always @(negedge clock) begin
        if (!ctrl_reset && !flush && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_idx: got %0d, expected none", out_idx);
            end else begin
                if (out_idx !== exp_q[0]) begin
                    fails++;
                    $display("FAIL stream_idx: got %0d, expected %0d", out_idx, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (hs_count == 0) first_idx = out_idx;
            last_idx = out_idx;
            hs_count++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue every set bit of a mask in ascending order.
    task automatic push_mask(input logic [WIDTH-1:0] m);
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) exp_q.push_back(IDX_W'(i));
        end
    endtask

    task automatic drive_req(input logic [WIDTH-1:0] m);
        req_valid = 1'b1;
        req_mask  = m;
        tick();
        req_valid = 1'b0;
        req_mask  = '0;
    endtask

    // Run until the DUT is empty and every queued index was seen.
    task automatic wait_drain(input int budget, input bit rand_ready);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (empty && exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        check("drain_done", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 1, 5'd0, 5'd0};
        vecs[1] = '{32'h8000_0000, 1, 5'd31, 5'd31};
        vecs[2] = '{32'h0000_0000, 0, 5'd0, 5'd0};
        vecs[3] = '{32'hAAAA_AAAA, 16, 5'd1, 5'd31};
        vecs[4] = '{32'h0001_0100, 2, 5'd8, 5'd16};
        vecs[5] = '{32'h7FFF_FFFE, 30, 5'd1, 5'd30};

        // Reset state
        tick();
        tick();
        ctrl_reset = 1'b0;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_state", {31'd0, fsm_state}, {31'd0, IDLE});

        // Basic stream 0, 5, 31 with two-cycle latency
        out_ready = 1'b1;
        push_mask(32'h8000_0021);
        drive_req(32'h8000_0021);
        check("lat_valid_t1", {31'd0, out_valid}, 32'd0);
        check("lat_pending_t1", pending, 32'h8000_0021);
        tick();
        check("lat_valid_t2", {31'd0, out_valid}, 32'd1);
        check("seq_idx0", 32'(out_idx), 32'd0);
        check("seq_pending0", pending, 32'h8000_0020);
        tick();
        check("seq_idx5", 32'(out_idx), 32'd5);
        tick();
        check("seq_idx31", 32'(out_idx), 32'd31);
        check("seq_pending_empty", pending, 32'd0);
        tick();
        check("seq_done_valid", {31'd0, out_valid}, 32'd0);
        check("seq_done_empty", {31'd0, empty}, 32'd1);
        check("seq_q_empty", exp_q.size(), 32'd0);

        // Backpressure holds index 1 while bit 2 waits
        out_ready = 1'b0;
        push_mask(32'h0000_0006);
        drive_req(32'h0000_0006);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_idx", 32'(out_idx), 32'd1);
            check("bp_pending", pending, 32'h4);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idx", 32'(out_idx), 32'd2);
        check("bp_release_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_done_empty", {31'd0, empty}, 32'd1);

        // Re-request of bit 3 in the same edge it is loaded
        push_mask(32'h8);
        push_mask(32'h8);
        req_valid = 1'b1;
        req_mask  = 32'h8;
        tick();
        tick();
        req_valid = 1'b0;
        req_mask  = '0;
        check("coll_idx_first", 32'(out_idx), 32'd3);
        check("coll_pending_kept", pending, 32'h8);
        tick();
        check("coll_idx_second", 32'(out_idx), 32'd3);
        check("coll_pending_clear", pending, 32'd0);
        tick();
        check("coll_done_empty", {31'd0, empty}, 32'd1);
        check("coll_q_empty", exp_q.size(), 32'd0);

        // Flush with a request in the same cycle
        out_ready = 1'b0;
        drive_req(32'hFFFF_FFFF);
        check("fl_pending_full", pending, 32'hFFFF_FFFF);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_mask  = 32'hFFFF_FFFF;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        req_mask  = '0;
        check("fl_pending", pending, 32'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_empty", {31'd0, empty}, 32'd1);
        tick();
        tick();
        check("fl_req_lost", {31'd0, empty}, 32'd1);

        // Reset mid-presentation with flush and request also high
        drive_req(32'h30);
        tick();
        check("rp_valid", {31'd0, out_valid}, 32'd1);
        check("rp_idx", 32'(out_idx), 32'd4);
        ctrl_reset = 1'b1;
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_mask   = 32'hFF;
        tick();
        ctrl_reset = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_mask   = '0;
        check("rp_valid_clr", {31'd0, out_valid}, 32'd0);
        check("rp_idx_clr", 32'(out_idx), 32'd0);
        check("rp_pending_clr", pending, 32'd0);
        check("rp_state", {31'd0, fsm_state}, {31'd0, IDLE});
        tick();
        check("rp_still_empty", {31'd0, empty}, 32'd1);
        out_ready = 1'b1;
        push_mask(32'h5);
        drive_req(32'h5);
        wait_drain(20, 1'b0);

        // Table of masks drained at full rate
        for (int v = 0; v < 6; v++) begin
            hs_count = 0;
            push_mask(vecs[v].mask);
            drive_req(vecs[v].mask);
            wait_drain(60, 1'b0);
            check("tbl_count", hs_count, vecs[v].exp_n);
            if (vecs[v].exp_n > 0) begin
                check("tbl_first", 32'(first_idx), 32'(vecs[v].exp_first));
                check("tbl_last", 32'(last_idx), 32'(vecs[v].exp_last));
            end
        end

        // Random masks under random backpressure
        for (int r = 0; r < 20; r++) begin
            logic [WIDTH-1:0] m;
            m = $urandom();
            hs_count = 0;
            push_mask(m);
            drive_req(m);
            wait_drain(400, 1'b1);
            check("rnd_count", hs_count, $countones(m));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
